tone_encode: RTL and testbench

Pitch-to-note encoder: the receive-side counterpart of the note-index-to-divider decoder. It measures the half-period of an incoming square wave on the 4 MHz system clock and recovers the 4-bit note index (0 = rest, 1–15 = notes) that produced it. It sits after the speaker divider output, or on an external tone input, and feeds the melody checker and display logic.

---
 rtl/tone_pkg.sv | 24 ++
 rtl/tone_ref_rom.sv | 20 ++
 rtl/tone_encode.sv | 194 +++++++++++++++++++
 tb/tb_tone_encode.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared constants for the note-index <-> half-period conversion blocks.
package tone_pkg;

    localparam int IDX_W  = 4;
    localparam int CNT_W  = 13;
    localparam int NOTE_N = 15;

    localparam logic [CNT_W-1:0] HCNT_MAX = 13'd8191;

    // Half-period in clk cycles for note index 1..15 (slot k holds index k+1).
    // Each entry equals 8192 minus the divider value used on the transmit side.
    localparam logic [CNT_W-1:0] REF_HALF [NOTE_N] = '{
        13'd7644, 13'd6810, 13'd6067, 13'd5727, 13'd5102,
        13'd4545, 13'd4050, 13'd3822, 13'd3405, 13'd3034,
        13'd2864, 13'd2551, 13'd2273, 13'd2025, 13'd1911
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } scan_state_e;

endpackage

// File: rtl/tone_ref_rom.sv
// Combinational note index -> reference half-period lookup. Index 0 (rest)
// and any unused code return 0.
module tone_ref_rom
    import tone_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    output logic [CNT_W-1:0] half_o
);

    // Table lookup.
    always_comb begin
        half_o = '0;
        for (int k = 0; k < NOTE_N; k++) begin
            if (idx_i == IDX_W'(k + 1)) begin
                half_o = REF_HALF[k];
            end
        end
    end

endmodule

// File: rtl/tone_encode.sv
// Pitch-to-note encoder: measures the half-period of tone_in and recovers
// the note index that produced it.
//
// state  | meaning
// S_IDLE | waiting for a capture
// S_SCAN | compare meas against ref(i), i = 1..15, one per cycle
// S_DONE | tolerance check on the best match, hand candidate to match rule
module tone_encode
    import tone_pkg::*;
#(
    parameter int TOL     = 48,
    parameter int MATCH_N = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tone_in,
    output logic [IDX_W-1:0] Index,
    output logic             valid,
    output logic             locked,
    output logic             err
);

    localparam logic [2:0] MATCH_LIM = 3'(MATCH_N);

    logic [2:0]       sync_q;
    logic             edge_det, capture;
    logic [CNT_W-1:0] hcnt_q, hcnt_d, meas_q, meas_d;
    logic             armed_q, armed_d, timeout_q, timeout_d;

    scan_state_e      state_q, state_d;
    logic [IDX_W-1:0] scan_i_q, scan_i_d, best_idx_q, best_idx_d;
    logic [CNT_W-1:0] best_diff_q, best_diff_d;
    logic [CNT_W-1:0] ref_half, diff;
    logic signed [CNT_W:0] delta;
    logic             done_ok, done_bad;

    logic             cand_vld_q, cand_bad_q;
    logic [IDX_W-1:0] cand_q;
    logic [2:0]       match_cnt_q, match_cnt_d;
    logic [IDX_W-1:0] prev_q, prev_d, index_q, index_d;
    logic             valid_q, valid_d, locked_q, locked_d, err_q, err_d;

    // Bits 0/1 synchronize, bit 2 is the previous synchronized level.
    assign edge_det = sync_q[1] ^ sync_q[2];
    assign capture  = edge_det & armed_q;

    tone_ref_rom u_rom (
        .idx_i  (scan_i_q),
        .half_o (ref_half)
    );

    assign delta = $signed({1'b0, meas_q}) - $signed({1'b0, ref_half});
    assign diff  = delta[CNT_W] ? CNT_W'(-delta) : CNT_W'(delta);

    // Half-period counter, arming and timeout detection.
    always_comb begin
        hcnt_d    = (hcnt_q == HCNT_MAX) ? HCNT_MAX : hcnt_q + 13'd1;
        armed_d   = armed_q;
        meas_d    = meas_q;
        timeout_d = 1'b0;
        if (edge_det) begin
            hcnt_d  = '0;
            armed_d = 1'b1;
            if (armed_q) meas_d = hcnt_q + 13'd1;
        end else if (hcnt_q == HCNT_MAX - 13'd1) begin
            armed_d   = 1'b0;
            timeout_d = 1'b1;
        end
    end

    // Synchronizer and measurement registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            hcnt_q    <= '0;
            armed_q   <= 1'b0;
            meas_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[1:0], tone_in};
            hcnt_q    <= hcnt_d;
            armed_q   <= armed_d;
            meas_q    <= meas_d;
            timeout_q <= timeout_d;
        end
    end

    // Search FSM next state; a new capture always restarts the scan.
    always_comb begin
        state_d     = state_q;
        scan_i_d    = scan_i_q;
        best_diff_d = best_diff_q;
        best_idx_d  = best_idx_q;
        done_ok     = 1'b0;
        done_bad    = 1'b0;
        case (state_q)
            S_IDLE: ;
            S_SCAN: begin
                if (diff < best_diff_q) begin
                    best_diff_d = diff;
                    best_idx_d  = scan_i_q;
                end
                if (scan_i_q == 4'd15) state_d = S_DONE;
                else                   scan_i_d = scan_i_q + 4'd1;
            end
            S_DONE: begin
                if (int'(best_diff_q) <= TOL) done_ok  = 1'b1;
                else                          done_bad = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (capture) begin
            state_d     = S_SCAN;
            scan_i_d    = 4'd1;
            best_diff_d = HCNT_MAX;
            best_idx_d  = '0;
            done_ok     = 1'b0;
            done_bad    = 1'b0;
        end
    end

    // Search FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            scan_i_q    <= '0;
            best_diff_q <= HCNT_MAX;
            best_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            scan_i_q    <= scan_i_d;
            best_diff_q <= best_diff_d;
            best_idx_q  <= best_idx_d;
        end
    end

    // Match rule on the registered candidate (scan result or timeout rest).
    always_comb begin
        match_cnt_d = match_cnt_q;
        prev_d      = prev_q;
        index_d     = index_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        err_d       = 1'b0;
        if (cand_bad_q) begin
            err_d       = 1'b1;
            match_cnt_d = '0;
            locked_d    = 1'b0;
        end else if (cand_vld_q) begin
            if (cand_q != prev_q)             match_cnt_d = 3'd1;
            else if (match_cnt_q < MATCH_LIM) match_cnt_d = match_cnt_q + 3'd1;
            prev_d = cand_q;
            if (match_cnt_d == MATCH_LIM) begin
                index_d  = cand_q;
                valid_d  = 1'b1;
                locked_d = 1'b1;
            end else begin
                locked_d = 1'b0;
            end
        end
    end

    // Candidate stage and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_vld_q  <= 1'b0;
            cand_bad_q  <= 1'b0;
            cand_q      <= '0;
            match_cnt_q <= '0;
            prev_q      <= '0;
            index_q     <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cand_vld_q  <= done_ok | (timeout_q & ~done_bad);
            cand_bad_q  <= done_bad;
            cand_q      <= done_ok ? best_idx_q : '0;
            match_cnt_q <= match_cnt_d;
            prev_q      <= prev_d;
            index_q     <= index_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
        end
    end

    assign Index  = index_q;
    assign valid  = valid_q;
    assign locked = locked_q;
    assign err    = err_q;

endmodule

// File: tb/tb_tone_encode.sv
// Directed bench for tone_encode. dut_a uses the default TOL/MATCH_N;
// dut_b (TOL = 60, MATCH_N = 1) shares the same input and confirms every
// in-tolerance candidate immediately.
module tb_tone_encode;

    localparam int SETTLE = 30;

    logic       clk = 1'b0;
    logic       rst;
    logic       tone_in;
    logic [3:0] index_a, index_b;
    logic       valid_a, valid_b, locked_a, locked_b, err_a, err_b;

    int checks = 0;
    int errors = 0;
    int nvalid_a = 0, nerr_a = 0, nvalid_b = 0, nerr_b = 0;

    tone_encode dut_a (
        .clk(clk), .rst(rst), .tone_in(tone_in),
        .Index(index_a), .valid(valid_a), .locked(locked_a), .err(err_a)
    );

    tone_encode #(.TOL(60), .MATCH_N(1)) dut_b (
        .clk(clk), .rst(rst), .tone_in(tone_in),
        .Index(index_b), .valid(valid_b), .locked(locked_b), .err(err_b)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled on the inactive edge.
    always @(negedge clk) begin
        if (valid_a) nvalid_a <= nvalid_a + 1;
        if (err_a)   nerr_a   <= nerr_a + 1;
        if (valid_b) nvalid_b <= nvalid_b + 1;
        if (err_b)   nerr_b   <= nerr_b + 1;
    end

    // k edges spaced n cycles apart; the first wait absorbs the previous settle.
    task automatic run_tone(input int n, input int k);
        for (int e = 0; e < k; e++) begin
            repeat ((e == 0) ? n - SETTLE : n) @(negedge clk);
            tone_in = ~tone_in;
        end
        repeat (SETTLE) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tone_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (index_a !== 4'd0) begin errors++; $display("FAIL reset_index: got %0d want 0", index_a); end
        checks++; if ({valid_a, locked_a, err_a} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {valid_a, locked_a, err_a}); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({index_a, locked_a} !== 5'd0) begin errors++; $display("FAIL reset_release: got %b want 0", {index_a, locked_a}); end
        checks++; if ({index_b, locked_b} !== 5'd0) begin errors++; $display("FAIL reset_b: got %b want 0", {index_b, locked_b}); end
    endtask

    task automatic test_lock();
        int v0;
        v0 = nvalid_a;
        run_tone(5102, 2);
        checks++; if (index_a !== 4'd0) begin errors++; $display("FAIL lock_first_index: got %0d want 0", index_a); end
        checks++; if (locked_a !== 1'b0) begin errors++; $display("FAIL lock_first_locked: got %b want 0", locked_a); end
        checks++; if (nvalid_a !== v0) begin errors++; $display("FAIL lock_first_valid: got %0d want %0d", nvalid_a, v0); end
        checks++; if (index_b !== 4'd5) begin errors++; $display("FAIL lock_b_index: got %0d want 5", index_b); end
        run_tone(5102, 1);
        checks++; if (index_a !== 4'd5) begin errors++; $display("FAIL lock_index: got %0d want 5", index_a); end
        checks++; if (locked_a !== 1'b1) begin errors++; $display("FAIL lock_locked: got %b want 1", locked_a); end
        checks++; if (nvalid_a !== v0 + 1) begin errors++; $display("FAIL lock_valid: got %0d want %0d", nvalid_a, v0 + 1); end
    endtask

    task automatic test_tolerance();
        int v0, e0, eb;
        v0 = nvalid_a;
        e0 = nerr_a;
        eb = nerr_b;
        run_tone(5142, 1);
        checks++; if (index_a !== 4'd5) begin errors++; $display("FAIL tol_in_index: got %0d want 5", index_a); end
        checks++; if (nvalid_a !== v0 + 1) begin errors++; $display("FAIL tol_in_valid: got %0d want %0d", nvalid_a, v0 + 1); end
        checks++; if (nerr_a !== e0) begin errors++; $display("FAIL tol_in_err: got %0d want %0d", nerr_a, e0); end
        run_tone(5202, 2);
        checks++; if (nerr_a !== e0 + 2) begin errors++; $display("FAIL tol_out_err: got %0d want %0d", nerr_a, e0 + 2); end
        checks++; if (index_a !== 4'd5) begin errors++; $display("FAIL tol_out_index: got %0d want 5", index_a); end
        checks++; if (locked_a !== 1'b0) begin errors++; $display("FAIL tol_out_locked: got %b want 0", locked_a); end
        checks++; if (nvalid_a !== v0 + 1) begin errors++; $display("FAIL tol_out_valid: got %0d want %0d", nvalid_a, v0 + 1); end
        checks++; if (nerr_b !== eb + 2) begin errors++; $display("FAIL tol_out_err_b: got %0d want %0d", nerr_b, eb + 2); end
    endtask

    task automatic test_alternate();
        int alt [3] = '{3405, 3034, 3405};
        int v0;
        v0 = nvalid_a;
        for (int s = 0; s < 3; s++) begin
            run_tone(alt[s], 1);
            checks++; if (locked_a !== 1'b0) begin errors++; $display("FAIL alt_locked step %0d: got %b want 0", s, locked_a); end
        end
        checks++; if (index_a !== 4'd5) begin errors++; $display("FAIL alt_index: got %0d want 5", index_a); end
        checks++; if (nvalid_a !== v0) begin errors++; $display("FAIL alt_valid: got %0d want %0d", nvalid_a, v0); end
        checks++; if (index_b !== 4'd9) begin errors++; $display("FAIL alt_b_index: got %0d want 9", index_b); end
    endtask

    task automatic test_tie();
        int e0;
        e0 = nerr_a;
        run_tone(1968, 2);
        checks++; if (index_b !== 4'd14) begin errors++; $display("FAIL tie_b_index: got %0d want 14", index_b); end
        checks++; if (nerr_a !== e0 + 2) begin errors++; $display("FAIL tie_a_err: got %0d want %0d", nerr_a, e0 + 2); end
        checks++; if (index_a !== 4'd5) begin errors++; $display("FAIL tie_a_index: got %0d want 5", index_a); end
    endtask

    task automatic test_reset_midscan();
        int v1;
        repeat (1911 - SETTLE) @(negedge clk);
        tone_in = ~tone_in;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        tone_in = 1'b0;
        #1;
        checks++; if (index_a !== 4'd0) begin errors++; $display("FAIL rst_scan_index: got %0d want 0", index_a); end
        checks++; if ({valid_a, locked_a, err_a} !== 3'b000) begin errors++; $display("FAIL rst_scan_flags: got %b want 000", {valid_a, locked_a, err_a}); end
        checks++; if (index_b !== 4'd0) begin errors++; $display("FAIL rst_scan_b_index: got %0d want 0", index_b); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        v1 = nvalid_a;
        run_tone(1911, 2);
        checks++; if (index_a !== 4'd0) begin errors++; $display("FAIL rst_after_index: got %0d want 0", index_a); end
        checks++; if (nvalid_a !== v1) begin errors++; $display("FAIL rst_after_valid: got %0d want %0d", nvalid_a, v1); end
        checks++; if (index_b !== 4'd15) begin errors++; $display("FAIL rst_after_b_index: got %0d want 15", index_b); end
        run_tone(1911, 1);
        checks++; if (index_a !== 4'd15) begin errors++; $display("FAIL rst_relock_index: got %0d want 15", index_a); end
        checks++; if (locked_a !== 1'b1) begin errors++; $display("FAIL rst_relock_locked: got %b want 1", locked_a); end
        checks++; if (nvalid_a !== v1 + 1) begin errors++; $display("FAIL rst_relock_valid: got %0d want %0d", nvalid_a, v1 + 1); end
    endtask

    task automatic test_timeout();
        int v0;
        v0 = nvalid_a;
        repeat (8200) @(negedge clk);
        checks++; if (index_a !== 4'd15) begin errors++; $display("FAIL to1_index: got %0d want 15", index_a); end
        checks++; if (locked_a !== 1'b0) begin errors++; $display("FAIL to1_locked: got %b want 0", locked_a); end
        checks++; if (nvalid_a !== v0) begin errors++; $display("FAIL to1_valid: got %0d want %0d", nvalid_a, v0); end
        checks++; if (index_b !== 4'd0) begin errors++; $display("FAIL to1_b_index: got %0d want 0", index_b); end
        tone_in = ~tone_in;
        repeat (8230) @(negedge clk);
        checks++; if (index_a !== 4'd0) begin errors++; $display("FAIL to2_index: got %0d want 0", index_a); end
        checks++; if (nvalid_a !== v0 + 1) begin errors++; $display("FAIL to2_valid: got %0d want %0d", nvalid_a, v0 + 1); end
        checks++; if (locked_a !== 1'b1) begin errors++; $display("FAIL to2_locked: got %b want 1", locked_a); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_tolerance();
        test_alternate();
        test_tie();
        test_reset_midscan();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
